// File: rtl/mem_access_unit.sv
// Purpose: MEM-stage load/store unit (LDW/LDB/STW/STB plus indirect LDI/STI)
//          driving a held request/response data-memory port.
// Latency: IDLE -> DATA (>=1 cycle) -> DONE; indirect ops add one PTR phase (>=1 cycle).
// Backpressure: o_stall holds upstream from access start until DONE; each
//               memory request is held stable until i_mem_resp is sampled high.
//
// Ports:
//   i_clk, i_reset         clock, synchronous active-high reset
//   i_valid_in, i_op       instruction present in MEM and its memory opcode
//   i_addr_in              effective address from EX
//   i_store_data           store source register value
//   i_advance              pipeline leaving MEM this cycle (releases DONE)
//   i_mem_resp, i_mem_rdata  memory completion and read data
//   o_mem_addr/read/write/wdata/byte_enable  registered memory request
//   o_load_data, o_done    registered load result, access complete
//   o_stall                hold request to the hazard unit
module mem_access_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  localparam int LANES = DATA_W / 8,
  localparam int LSB_W = $clog2(DATA_W / 8)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid_in,
  input  logic [2:0]        i_op,
  input  logic [ADDR_W-1:0] i_addr_in,
  input  logic [DATA_W-1:0] i_store_data,
  input  logic              i_advance,
  input  logic              i_mem_resp,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [LANES-1:0]  o_mem_byte_enable,
  output logic [DATA_W-1:0] o_load_data,
  output logic              o_done,
  output logic              o_stall
);

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_LDW  = 3'd1;
  localparam logic [2:0] OP_LDB  = 3'd2;
  localparam logic [2:0] OP_STW  = 3'd3;
  localparam logic [2:0] OP_STB  = 3'd4;
  localparam logic [2:0] OP_LDI  = 3'd5;
  localparam logic [2:0] OP_STI  = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PTR  = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // Opcode / address helpers
  // ---------------------------------------------------------------------
  function automatic logic is_access(input logic [2:0] op);
    return (op != OP_NONE) && (op != OP_RSVD);
  endfunction

  function automatic logic is_indirect(input logic [2:0] op);
    return (op == OP_LDI) || (op == OP_STI);
  endfunction

  function automatic logic is_load(input logic [2:0] op);
    return (op == OP_LDW) || (op == OP_LDB) || (op == OP_LDI);
  endfunction

  // Word accesses are always lane-aligned on the bus.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:LSB_W], {LSB_W{1'b0}}};
  endfunction

  function automatic logic [7:0] byte_sel(input logic [DATA_W-1:0] d,
                                          input logic [LSB_W-1:0]  lane);
    logic [7:0] res;
    res = 8'h00;
    for (int k = 0; k < LANES; k++) begin
      if (k == int'(lane)) res = d[k*8 +: 8];
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------
  // State and latched operands
  // ---------------------------------------------------------------------
  state_t              r_state, w_state_nxt;
  logic [2:0]          r_op, w_op_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [DATA_W-1:0]   r_sdata, w_sdata_nxt;
  logic [ADDR_W-1:0]   r_ptr, w_ptr_nxt;
  logic [DATA_W-1:0]   r_load, w_load_nxt;
  logic                w_stall;

  // Registered request outputs and their next values
  logic [ADDR_W-1:0]   r_mem_addr, w_req_addr;
  logic                r_mem_read, w_req_read;
  logic                r_mem_write, w_req_write;
  logic [DATA_W-1:0]   r_mem_wdata, w_req_wdata;
  logic [LANES-1:0]    r_mem_be, w_req_be;
  logic                r_done;

  logic [ADDR_W-1:0]   w_base;
  logic [LSB_W-1:0]    w_lane;

  // ---------------------------------------------------------------------
  // Next-state and operand latching
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_addr_nxt  = r_addr;
    w_sdata_nxt = r_sdata;
    w_ptr_nxt   = r_ptr;
    w_load_nxt  = r_load;
    w_stall     = 1'b0;

    case (r_state)
      S_IDLE: begin
        // NONE/reserved opcodes pass through MEM without touching memory.
        if (i_valid_in && is_access(i_op)) begin
          w_op_nxt    = i_op;
          w_addr_nxt  = i_addr_in;
          w_sdata_nxt = i_store_data;
          w_stall     = 1'b1;
          w_state_nxt = is_indirect(i_op) ? S_PTR : S_DATA;
        end
      end

      S_PTR: begin
        w_stall = 1'b1;
        if (i_mem_resp) begin
          w_ptr_nxt   = ADDR_W'(i_mem_rdata);
          w_state_nxt = S_DATA;
        end
      end

      S_DATA: begin
        w_stall = 1'b1;
        if (i_mem_resp) begin
          if (is_load(r_op)) begin
            // Byte loads are never indirect, so the lane comes from the
            // latched EX address.
            if (r_op == OP_LDB)
              w_load_nxt = {{(DATA_W-8){1'b0}}, byte_sel(i_mem_rdata, r_addr[LSB_W-1:0])};
            else
              w_load_nxt = i_mem_rdata;
          end
          w_state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        if (i_advance) w_state_nxt = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Request generation. Decoded from the *next* state and operands so the
  // request flops line up with the state register: requests appear in the
  // same cycle as PTR/DATA and drop the cycle after the response. The only
  // i_mem_resp influence is through next-state, never a direct output path.
  // ---------------------------------------------------------------------
  assign w_base = is_indirect(w_op_nxt) ? w_ptr_nxt : w_addr_nxt;
  assign w_lane = w_base[LSB_W-1:0];

  always_comb begin
    w_req_read  = 1'b0;
    w_req_write = 1'b0;
    w_req_addr  = '0;
    w_req_wdata = '0;
    w_req_be    = '0;

    case (w_state_nxt)
      S_PTR: begin
        w_req_read = 1'b1;
        w_req_addr = word_addr(w_addr_nxt);
      end

      S_DATA: begin
        case (w_op_nxt)
          OP_LDW, OP_LDI: begin
            w_req_read = 1'b1;
            w_req_addr = word_addr(w_base);
          end
          OP_STW, OP_STI: begin
            w_req_write = 1'b1;
            w_req_addr  = word_addr(w_base);
            w_req_wdata = w_sdata_nxt;
            w_req_be    = '1;
          end
          OP_LDB: begin
            w_req_read = 1'b1;
            w_req_addr = w_base;
          end
          OP_STB: begin
            // Replicate the byte on every lane; the one-hot mask picks it.
            w_req_write      = 1'b1;
            w_req_addr       = w_base;
            w_req_wdata      = {LANES{w_sdata_nxt[7:0]}};
            w_req_be[w_lane] = 1'b1;
          end
          default: ;
        endcase
      end

      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_op        <= OP_NONE;
      r_addr      <= '0;
      r_sdata     <= '0;
      r_ptr       <= '0;
      r_load      <= '0;
      r_mem_addr  <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_op        <= w_op_nxt;
      r_addr      <= w_addr_nxt;
      r_sdata     <= w_sdata_nxt;
      r_ptr       <= w_ptr_nxt;
      r_load      <= w_load_nxt;
      r_mem_addr  <= w_req_addr;
      r_mem_read  <= w_req_read;
      r_mem_write <= w_req_write;
      r_mem_wdata <= w_req_wdata;
      r_mem_be    <= w_req_be;
      r_done      <= (w_state_nxt == S_DONE);
    end
  end

  assign o_mem_addr        = r_mem_addr;
  assign o_mem_read        = r_mem_read;
  assign o_mem_write       = r_mem_write;
  assign o_mem_wdata       = r_mem_wdata;
  assign o_mem_byte_enable = r_mem_be;
  assign o_load_data       = r_load;
  assign o_done            = r_done;
  assign o_stall           = w_stall;

endmodule

// File: tb/tb_mem_access_unit.sv
// Purpose: self-checking bench for mem_access_unit (16-bit and 32-bit builds).
// Latency: fixed-length sequences, no open-ended waits.
// Backpressure: memory responses are driven by the bench with per-vector wait counts.
module tb_mem_access_unit;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_LDW  = 3'd1;
  localparam logic [2:0] OP_LDB  = 3'd2;
  localparam logic [2:0] OP_STW  = 3'd3;
  localparam logic [2:0] OP_STB  = 3'd4;
  localparam logic [2:0] OP_LDI  = 3'd5;
  localparam logic [2:0] OP_STI  = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // 16-bit instance signals
  logic        valid_in, advance, mem_resp;
  logic [2:0]  op;
  logic [15:0] addr_in, store_data, mem_rdata;
  logic [15:0] mem_addr, mem_wdata, load_data;
  logic        mem_read, mem_write, done, stall;
  logic [1:0]  mem_be;

  // 32-bit instance signals
  logic        valid32, adv32, resp32;
  logic [2:0]  op32;
  logic [15:0] addr32;
  logic [31:0] sdata32, rdata32;
  logic [15:0] maddr32;
  logic [31:0] wdata32, load32;
  logic        read32, write32, done32, stall32;
  logic [3:0]  be32;

  mem_access_unit #(.DATA_W(16), .ADDR_W(16)) dut (
    .i_clk(clk), .i_reset(reset), .i_valid_in(valid_in), .i_op(op),
    .i_addr_in(addr_in), .i_store_data(store_data), .i_advance(advance),
    .i_mem_resp(mem_resp), .i_mem_rdata(mem_rdata),
    .o_mem_addr(mem_addr), .o_mem_read(mem_read), .o_mem_write(mem_write),
    .o_mem_wdata(mem_wdata), .o_mem_byte_enable(mem_be),
    .o_load_data(load_data), .o_done(done), .o_stall(stall)
  );

  mem_access_unit #(.DATA_W(32), .ADDR_W(16)) dut32 (
    .i_clk(clk), .i_reset(reset), .i_valid_in(valid32), .i_op(op32),
    .i_addr_in(addr32), .i_store_data(sdata32), .i_advance(adv32),
    .i_mem_resp(resp32), .i_mem_rdata(rdata32),
    .o_mem_addr(maddr32), .o_mem_read(read32), .o_mem_write(write32),
    .o_mem_wdata(wdata32), .o_mem_byte_enable(be32),
    .o_load_data(load32), .o_done(done32), .o_stall(stall32)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sb_pop_chk(input string name, input logic [31:0] act);
    logic [31:0] e;
    n_chk++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: got %h, expected an entry but scoreboard empty", name, act);
    end else begin
      e = sb_q.pop_front();
      if (act !== e) begin
        n_err++;
        $display("FAIL %s: got %h, expected %h", name, act, e);
      end
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [15:0] addr;
    logic [15:0] sdata;
    int          wait_n;   // idle cycles before the data-phase response
    int          hold_n;   // cycles DONE is held with advance=0
    logic [15:0] rdata1;   // pointer read data (indirect only)
    logic [15:0] rdata2;   // data-phase read data
    logic [15:0] exp_addr1;
    logic [15:0] exp_addr2;
    logic        exp_rd;
    logic        exp_wr;
    logic [15:0] exp_wdata;
    logic [1:0]  exp_be;
    logic [15:0] exp_load;
  } vec_t;

  vec_t vecs[9];

  // Runs one access on the 16-bit instance. Inputs change and outputs are
  // sampled on the falling edge.
  task automatic do_vec(input vec_t v);
    logic [31:0] ld_exp;
    @(negedge clk);
    valid_in = 1'b1; op = v.op; addr_in = v.addr; store_data = v.sdata;
    advance = 1'b0; mem_resp = 1'b0;
    #1;
    chk("start_stall", 32'(stall), 32'd1);
    sb_q.push_back(32'(v.exp_load));
    @(negedge clk);
    // Upstream garbage while stalled must not matter.
    op = 3'($urandom_range(7, 0));
    addr_in = 16'($urandom);
    store_data = 16'($urandom);
    valid_in = 1'($urandom_range(1, 0));
    if (v.op == OP_LDI || v.op == OP_STI) begin
      chk("ptr_read", 32'(mem_read), 32'd1);
      chk("ptr_write", 32'(mem_write), 32'd0);
      chk("ptr_addr", 32'(mem_addr), 32'(v.exp_addr1));
      chk("ptr_be", 32'(mem_be), 32'd0);
      chk("ptr_stall", 32'(stall), 32'd1);
      mem_resp = 1'b1; mem_rdata = v.rdata1;
      @(negedge clk);
      mem_resp = 1'b0; mem_rdata = 16'($urandom);
    end
    for (int i = 0; i <= v.wait_n; i++) begin
      chk("data_addr", 32'(mem_addr), 32'(v.exp_addr2));
      chk("data_read", 32'(mem_read), 32'(v.exp_rd));
      chk("data_write", 32'(mem_write), 32'(v.exp_wr));
      chk("data_stall", 32'(stall), 32'd1);
      chk("data_done", 32'(done), 32'd0);
      if (v.exp_wr) begin
        chk("data_wdata", 32'(mem_wdata), 32'(v.exp_wdata));
        chk("data_be", 32'(mem_be), 32'(v.exp_be));
      end
      if (i == v.wait_n) begin
        mem_resp = 1'b1; mem_rdata = v.rdata2;
      end
      @(negedge clk);
    end
    mem_resp = 1'b0;
    for (int h = 0; h <= v.hold_n; h++) begin
      chk("done_flag", 32'(done), 32'd1);
      chk("done_stall", 32'(stall), 32'd0);
      chk("done_read", 32'(mem_read), 32'd0);
      chk("done_write", 32'(mem_write), 32'd0);
      if (h == 0) begin
        ld_exp = sb_q.size() > 0 ? sb_q[0] : 32'hx;
        sb_pop_chk("load_data", 32'(load_data));
      end else begin
        chk("load_hold", 32'(load_data), ld_exp);
      end
      // Stray responses in DONE must be ignored.
      mem_resp = (h < v.hold_n);
      advance = (h == v.hold_n);
      @(negedge clk);
    end
    advance = 1'b0; mem_resp = 1'b0; valid_in = 1'b0;
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_read", 32'(mem_read), 32'd0);
    chk("idle_write", 32'(mem_write), 32'd0);
  endtask

  initial begin
    vecs[0] = '{OP_LDW, 16'h3001, 16'h0000, 2, 0, 16'h0000, 16'hBEEF, 16'h0000, 16'h3000, 1'b1, 1'b0, 16'h0000, 2'b00, 16'hBEEF};
    vecs[1] = '{OP_LDB, 16'h4005, 16'h0000, 0, 0, 16'h0000, 16'h12AB, 16'h0000, 16'h4005, 1'b1, 1'b0, 16'h0000, 2'b00, 16'h0012};
    vecs[2] = '{OP_LDB, 16'h4004, 16'h0000, 1, 0, 16'h0000, 16'h12AB, 16'h0000, 16'h4004, 1'b1, 1'b0, 16'h0000, 2'b00, 16'h00AB};
    vecs[3] = '{OP_STB, 16'h5003, 16'h77C4, 1, 0, 16'h0000, 16'hDEAD, 16'h0000, 16'h5003, 1'b0, 1'b1, 16'hC4C4, 2'b10, 16'h00AB};
    vecs[4] = '{OP_STW, 16'h2223, 16'h1234, 0, 0, 16'h0000, 16'hDEAD, 16'h0000, 16'h2222, 1'b0, 1'b1, 16'h1234, 2'b11, 16'h00AB};
    vecs[5] = '{OP_LDI, 16'h6000, 16'h0000, 1, 0, 16'h7002, 16'h0042, 16'h6000, 16'h7002, 1'b1, 1'b0, 16'h0000, 2'b00, 16'h0042};
    vecs[6] = '{OP_STI, 16'h6101, 16'hA5A5, 0, 3, 16'h8003, 16'hDEAD, 16'h6100, 16'h8002, 1'b0, 1'b1, 16'hA5A5, 2'b11, 16'h0042};
    vecs[7] = '{OP_STB, 16'h5002, 16'h0033, 0, 0, 16'h0000, 16'hDEAD, 16'h0000, 16'h5002, 1'b0, 1'b1, 16'h3333, 2'b01, 16'h0042};
    vecs[8] = '{OP_LDB, 16'h1001, 16'h0000, 0, 0, 16'h0000, 16'hFF80, 16'h0000, 16'h1001, 1'b1, 1'b0, 16'h0000, 2'b00, 16'h00FF};

    reset = 1'b1;
    valid_in = 0; advance = 0; mem_resp = 0; op = OP_NONE;
    addr_in = 0; store_data = 0; mem_rdata = 0;
    valid32 = 0; adv32 = 0; resp32 = 0; op32 = OP_NONE;
    addr32 = 0; sdata32 = 0; rdata32 = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_read", 32'(mem_read), 32'd0);
    chk("rst_write", 32'(mem_write), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    chk("rst_load", 32'(load_data), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);

    // NONE and reserved opcodes: no stall, no access
    valid_in = 1'b1; op = OP_NONE; #1;
    chk("none_stall", 32'(stall), 32'd0);
    @(negedge clk);
    chk("none_read", 32'(mem_read), 32'd0);
    chk("none_done", 32'(done), 32'd0);
    op = OP_RSVD; #1;
    chk("rsvd_stall", 32'(stall), 32'd0);
    @(negedge clk);
    chk("rsvd_read", 32'(mem_read), 32'd0);
    chk("rsvd_write", 32'(mem_write), 32'd0);
    chk("rsvd_done", 32'(done), 32'd0);
    valid_in = 1'b0;
    // Response in IDLE is ignored
    mem_resp = 1'b1; mem_rdata = 16'h5555;
    @(negedge clk);
    mem_resp = 1'b0;
    chk("idle_resp_done", 32'(done), 32'd0);
    chk("idle_resp_load", 32'(load_data), 32'd0);

    for (int k = 0; k < 9; k++) do_vec(vecs[k]);

    // Reset during a PTR wait, then a late response
    @(negedge clk);
    valid_in = 1'b1; op = OP_LDI; addr_in = 16'h6000;
    @(negedge clk);
    valid_in = 1'b0;
    chk("rstptr_read", 32'(mem_read), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstptr_read0", 32'(mem_read), 32'd0);
    chk("rstptr_addr0", 32'(mem_addr), 32'd0);
    chk("rstptr_load0", 32'(load_data), 32'd0);
    chk("rstptr_stall0", 32'(stall), 32'd0);
    mem_resp = 1'b1; mem_rdata = 16'h1234;
    @(negedge clk);
    mem_resp = 1'b0;
    chk("late_resp_done", 32'(done), 32'd0);
    chk("late_resp_read", 32'(mem_read), 32'd0);
    chk("late_resp_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    chk("late_resp_done2", 32'(done), 32'd0);
    chk("late_resp_load", 32'(load_data), 32'd0);

    // 32-bit build: LDB from lane 2
    valid32 = 1'b1; op32 = OP_LDB; addr32 = 16'h0206;
    sb_q.push_back(32'h0000_0022);
    @(negedge clk);
    valid32 = 1'b0;
    chk("w32_ldb_addr", 32'(maddr32), 32'h0206);
    chk("w32_ldb_read", 32'(read32), 32'd1);
    resp32 = 1'b1; rdata32 = 32'h1122_3344;
    @(negedge clk);
    resp32 = 1'b0;
    chk("w32_ldb_done", 32'(done32), 32'd1);
    sb_pop_chk("w32_ldb_load", load32);
    adv32 = 1'b1;
    @(negedge clk);
    adv32 = 1'b0;

    // 32-bit build: STB at lane 3, reset mid-wait, late response
    valid32 = 1'b1; op32 = OP_STB; addr32 = 16'h0103; sdata32 = 32'h0000_005A;
    @(negedge clk);
    valid32 = 1'b0;
    for (int c = 0; c < 2; c++) begin
      chk("w32_stb_be", 32'(be32), 32'h8);
      chk("w32_stb_wdata", wdata32, 32'h5A5A_5A5A);
      chk("w32_stb_write", 32'(write32), 32'd1);
      chk("w32_stb_read", 32'(read32), 32'd0);
      chk("w32_stb_addr", 32'(maddr32), 32'h0103);
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("w32_rst_write", 32'(write32), 32'd0);
    chk("w32_rst_be", 32'(be32), 32'd0);
    chk("w32_rst_wdata", wdata32, 32'd0);
    chk("w32_rst_load", load32, 32'd0);
    resp32 = 1'b1;
    @(negedge clk);
    resp32 = 1'b0;
    chk("w32_late_done", 32'(done32), 32'd0);
    chk("w32_late_write", 32'(write32), 32'd0);
    chk("w32_late_stall", 32'(stall32), 32'd0);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised MEM-stage memory access controller for the pipelined LC-3b datapath. Successor to the current MEM stage.
- Generalises data width and byte lanes.
- Runs LDW/LDB/STW/STB and two-access indirect LDI/STI through one explicit state machine with a held request/response handshake.
- Provides a registered load result and a stall to the hazard unit.
- Sits between EX/MEM pipeline register and data-memory port.

Parameters:
- DATA_W, 16, data bus width; multiple of 8, >=16.
- ADDR_W, 16, address width.
- LANES, DATA_W/8, byte lanes (derived, not overridable).
- LSB_W, log2(LANES), address bits selecting a byte lane (derived).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- valid_in  in  1  instruction present in MEM stage.
- op  in  3  0 NONE, 1 LDW, 2 LDB, 3 STW, 4 STB, 5 LDI, 6 STI, 7 reserved (treated as NONE).
- addr_in  in  ADDR_W  effective address from EX (ALU result).
- store_data  in  DATA_W  source register value for stores.
- advance  in  1  pipeline advancing out of MEM this cycle.
- mem_resp  in  1  memory completed current request.
- mem_rdata  in  DATA_W  memory read data, valid with mem_resp.
- mem_addr  out  ADDR_W  request address.
- mem_read  out  1  read request.
- mem_write  out  1  write request.
- mem_wdata  out  DATA_W  write data.
- mem_byte_enable  out  LANES  write byte mask.
- load_data  out  DATA_W  registered load result.
- done  out  1  access complete; load_data valid.
- stall  out  1  hold upstream stages.

Behaviour:
- States: IDLE, PTR, DATA, DONE. Reset forces IDLE.
- Reset values (registered): mem_addr, mem_wdata, mem_byte_enable, load_data all 0; mem_read, mem_write, done all 0.
- Request outputs are driven only from registered state/latched operands. No combinational path from mem_resp to request outputs.
- IDLE:
  - On valid_in && op in {1..6}: latch op, addr_in, store_data.
  - LDI/STI go to PTR; all others go to DATA.
  - stall=1 combinationally in that cycle.
  - valid_in with NONE/reserved: stall=0, done=0, no state change.
- PTR:
  - mem_read=1, mem_addr = latched addr with low LSB_W bits cleared, byte_enable=0.
  - On mem_resp: pointer register <= mem_rdata; go DATA.
- DATA:
  - Address is the latched addr (or pointer for LDI/STI), low LSB_W bits cleared for word ops. Byte ops present the full address.
  - LDW/LDI: mem_read=1.
  - STW/STI: mem_write=1, wdata = store_data, byte_enable all ones.
  - LDB: mem_read=1.
  - STB: mem_write=1, wdata = store_data[7:0] replicated to all lanes, byte_enable one-hot at lane addr[LSB_W-1:0].
  - On mem_resp: loads capture load_data (words: mem_rdata; LDB: selected lane zero-extended to DATA_W). Go DONE.
- DONE:
  - done=1, stall=0, no request.
  - load_data holds until the next load capture. Stores leave it unchanged.
  - advance=1: go IDLE. advance=0: stay DONE.
- stall=1 in PTR and DATA, and in IDLE when starting an access. Otherwise stall=0.
- Handshake:
  - mem_read/mem_write, mem_addr, mem_wdata and byte_enable stay stable from request assertion until the cycle mem_resp is sampled high. They deassert the following cycle.
  - mem_read and mem_write are never both 1.
- mem_resp is ignored in IDLE and DONE.
- Minimum latency for a single-access op: IDLE, DATA (1 cycle if mem_resp is immediate), DONE. Indirect ops add one PTR phase.
- Reset mid-operation: next state IDLE, requests drop the following cycle, pointer and result cleared. A late mem_resp after reset is ignored.
- Upstream changes to op/addr_in/store_data while stalled have no effect; operands are latched.

Test Plan:
- LDW addr_in=0x3001, mem_rdata=0xBEEF after 2 wait cycles -> mem_addr=0x3000 held 3 cycles, load_data=0xBEEF, done=1 next cycle.
- LDB addr_in=0x4005, mem_rdata=0x12AB -> load_data=0x0012. Repeat with addr 0x4004 -> 0x00AB.
- STB addr_in=0x5003, store_data=0x77C4 -> mem_wdata=0xC4C4, byte_enable=2'b10, mem_write=1 until mem_resp, load_data unchanged.
- LDI addr_in=0x6000: first read returns 0x7002, second returns 0x0042 -> second mem_addr=0x7002, load_data=0x0042, stall=1 across both accesses.
- STI with advance=0 for 3 cycles in DONE -> stays DONE, done=1, no further request; advance=1 -> IDLE.
- Assert reset during PTR wait, then pulse mem_resp -> outputs zero, state IDLE, response ignored. Repeat with DATA_W=32 STB at lane 3 -> byte_enable=4'b1000.
